// File: rtl/fft_frame_sequencer_if.sv
// Avalon-ST sink bus toward the FFT core.
// Master drives the frame words, slave returns ready.
interface fft_frame_sequencer_if #(
  parameter int DATA_WIDTH = 12
);
  logic                  sink_valid;
  logic                  sink_ready;
  logic                  sink_sop;
  logic                  sink_eop;
  logic [DATA_WIDTH-1:0] sink_real;
  logic [DATA_WIDTH-1:0] sink_imag;

  modport master (
    output sink_valid, sink_sop, sink_eop,
    output sink_real, sink_imag,
    input  sink_ready
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop,
    input  sink_real, sink_imag,
    output sink_ready
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frames the sample stream into whole FFT_LEN frames
// for the FFT sink and counts frames coming back.
module fft_frame_sequencer #(
  parameter int DATA_WIDTH = 12,
  parameter int FFT_LEN    = 1024,
  parameter int LOG2_LEN   = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [15:0]           i_num_frames,
  input  logic                  i_sample_valid,
  input  logic [DATA_WIDTH-1:0] i_sample_in,
  input  logic                  i_source_valid,
  input  logic                  i_source_eop,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [15:0]           o_frames_sent,
  output logic [15:0]           o_frames_received,
  fft_frame_sequencer_if.master sink
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LOG2_LEN-1:0] LAST_IDX =
    LOG2_LEN'(FFT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_WAIT
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic [LOG2_LEN-1:0]   r_wr_idx;
  logic [LOG2_LEN-1:0]   r_rd_idx;
  logic [15:0]           r_wr_frames;
  logic [15:0]           r_num_frames;
  logic                  r_stop_pending;
  logic                  r_done;
  logic                  r_overflow;
  logic [15:0]           r_frames_sent;
  logic [15:0]           r_frames_received;

  logic w_empty, w_full, w_active, w_valid;
  logic w_rd, w_hold, w_wr, w_drop;
  logic w_last_wr, w_frames_done, w_eop_rd, w_src_eop;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) &&
                    (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_active = (r_state == S_RUN) ||
                    (r_state == S_DRAIN);
  assign w_valid  = w_active && !w_empty;
  assign w_rd     = w_valid && sink.sink_ready;
  // stop seen on a frame boundary: take no more samples
  assign w_hold   = r_stop_pending && (r_wr_idx == '0);
  assign w_wr     = (r_state == S_RUN) && !w_hold &&
                    i_sample_valid && (!w_full || w_rd);
  assign w_drop   = (r_state == S_RUN) && !w_hold &&
                    i_sample_valid && w_full && !w_rd;
  assign w_last_wr     = w_wr && (r_wr_idx == LAST_IDX);
  assign w_frames_done = (r_num_frames != '0) &&
    (r_wr_frames + 16'd1 == r_num_frames);
  assign w_eop_rd  = w_rd && (r_rd_idx == LAST_IDX);
  assign w_src_eop = (r_state != S_IDLE) &&
                     i_source_valid && i_source_eop;

  assign sink.sink_valid = w_valid;
  assign sink.sink_sop   = w_valid && (r_rd_idx == '0);
  assign sink.sink_eop   = w_valid && (r_rd_idx == LAST_IDX);
  assign sink.sink_real  =
    w_valid ? r_mem[r_rptr[AW-1:0]] : '0;
  assign sink.sink_imag  = '0;

  assign o_busy            = (r_state != S_IDLE);
  assign o_done            = r_done;
  assign o_overflow        = r_overflow;
  assign o_frames_sent     = r_frames_sent;
  assign o_frames_received = r_frames_received;

  // skid FIFO storage, written on accepted samples
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_sample_in;
  end

  // capture FSM, FIFO pointers, frame indices and counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state           <= S_IDLE;
      r_wptr            <= '0;
      r_rptr            <= '0;
      r_wr_idx          <= '0;
      r_rd_idx          <= '0;
      r_wr_frames       <= '0;
      r_num_frames      <= '0;
      r_stop_pending    <= 1'b0;
      r_done            <= 1'b0;
      r_overflow        <= 1'b0;
      r_frames_sent     <= '0;
      r_frames_received <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_wr) begin
        r_wptr   <= r_wptr + (AW+1)'(1);
        r_wr_idx <= r_wr_idx + LOG2_LEN'(1);
      end
      if (w_last_wr) r_wr_frames <= r_wr_frames + 16'd1;
      if (w_drop) r_overflow <= 1'b1;
      if (w_rd) begin
        r_rptr   <= r_rptr + (AW+1)'(1);
        r_rd_idx <= r_rd_idx + LOG2_LEN'(1);
      end
      if (w_eop_rd)
        r_frames_sent <= r_frames_sent + 16'd1;
      if (w_src_eop)
        r_frames_received <= r_frames_received + 16'd1;
      unique case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num_frames      <= i_num_frames;
            r_frames_sent     <= '0;
            r_frames_received <= '0;
            r_overflow        <= 1'b0;
            r_wr_idx          <= '0;
            r_rd_idx          <= '0;
            r_wr_frames       <= '0;
            r_stop_pending    <= 1'b0;
            r_wptr            <= '0;
            r_rptr            <= '0;
            r_state           <= S_RUN;
          end
        end
        S_RUN: begin
          if (i_stop) r_stop_pending <= 1'b1;
          if (w_hold)
            r_state <= S_DRAIN;
          else if (w_last_wr &&
                   (w_frames_done || r_stop_pending))
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_empty && (r_rd_idx == '0))
            r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_frames_received == r_frames_sent) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer with
// FFT_LEN=8 and FIFO_DEPTH=4.
module tb_fft_frame_sequencer;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic [15:0]   num_frames;
  logic          sample_valid;
  logic [DW-1:0] sample_in;
  logic          source_valid;
  logic          source_eop;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [15:0]   frames_sent;
  logic [15:0]   frames_received;

  fft_frame_sequencer_if #(.DATA_WIDTH(DW)) sink_if ();

  fft_frame_sequencer #(
    .DATA_WIDTH(DW),
    .FFT_LEN(8),
    .LOG2_LEN(3),
    .FIFO_DEPTH(4)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_start           (start),
    .i_stop            (stop),
    .i_num_frames      (num_frames),
    .i_sample_valid    (sample_valid),
    .i_sample_in       (sample_in),
    .i_source_valid    (source_valid),
    .i_source_eop      (source_eop),
    .o_busy            (busy),
    .o_done            (done),
    .o_overflow        (overflow),
    .o_frames_sent     (frames_sent),
    .o_frames_received (frames_received),
    .sink              (sink_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic rdy;
    logic vld;
    int   rv;
    logic sop;
    logic eop;
  } vec_t;

  task automatic chk(input string name, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_frames = 16'(n);
    step();
    start = 1'b0;
  endtask

  task automatic finish_frames(input int n,
                               input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      source_valid = 1'b1;
      source_eop = 1'b1;
      step();
    end
    source_valid = 1'b0;
    source_eop = 1'b0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (done) seen = 1;
      else step();
    end
    chk({tag, " done pulse"}, seen, 1);
    if (seen == 1) begin
      chk({tag, " busy at done"}, busy, 0);
      step();
      chk({tag, " done one cycle"}, done, 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " valid"}, sink_if.sink_valid, 0);
    chk({tag, " sop"}, sink_if.sink_sop, 0);
    chk({tag, " eop"}, sink_if.sink_eop, 0);
    chk({tag, " real"}, sink_if.sink_real, 0);
    chk({tag, " imag"}, sink_if.sink_imag, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " overflow"}, overflow, 0);
    chk({tag, " frames_sent"}, frames_sent, 0);
    chk({tag, " frames_rcvd"}, frames_received, 0);
  endtask

  initial begin
    vec_t tbl[14];
    int   expc[8];
    int   n;

    tbl[0]  = '{1'b1, 1'b0, 0,   1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 200, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 201, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 201, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 201, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 201, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 202, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 203, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 204, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 205, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 206, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 207, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 0,   1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 0,   1'b0, 1'b0};
    expc = '{300, 301, 302, 303, 307, 308, 309, 310};

    reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    num_frames = '0;
    sample_valid = 1'b0;
    sample_in = '0;
    source_valid = 1'b0;
    source_eop = 1'b0;
    sink_if.sink_ready = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    chk_all_zero("reset");

    // stop in IDLE is ignored
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("idle stop busy", busy, 0);

    // A: two frames; start+stop together, start wins
    sample_valid = 1'b1;
    start = 1'b1;
    stop = 1'b1;
    num_frames = 16'd2;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk("A busy", busy, 1);
    chk("A latency valid", sink_if.sink_valid, 0);
    sample_in = DW'(100);
    step();
    for (int t = 0; t < 16; t++) begin
      chk("A valid", sink_if.sink_valid, 1);
      chk("A real", sink_if.sink_real, 100 + t);
      chk("A sop", sink_if.sink_sop, int'(t % 8 == 0));
      chk("A eop", sink_if.sink_eop, int'(t % 8 == 7));
      if (t == 10) chk("A start ignored", frames_sent, 1);
      start = (t == 9);
      num_frames = 16'd5;
      sample_in = DW'(101 + t);
      step();
    end
    start = 1'b0;
    chk("A frames_sent", frames_sent, 2);
    chk("A drained", sink_if.sink_valid, 0);
    finish_frames(2, "A");

    // B: sink_ready low 3 cycles, table driven
    do_start(1);
    for (int i = 0; i < 14; i++) begin
      sink_if.sink_ready = tbl[i].rdy;
      sample_in = DW'(200 + i);
      chk("B valid", sink_if.sink_valid, tbl[i].vld);
      if (tbl[i].vld)
        chk("B real", sink_if.sink_real, tbl[i].rv);
      chk("B sop", sink_if.sink_sop, tbl[i].sop);
      chk("B eop", sink_if.sink_eop, tbl[i].eop);
      chk("B overflow", overflow, 0);
      step();
    end
    sink_if.sink_ready = 1'b1;
    chk("B frames_sent", frames_sent, 1);
    finish_frames(1, "B");

    // C: sink_ready low 6 cycles forces drops
    do_start(1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      sink_if.sink_ready = (i >= 7);
      sample_in = DW'(300 + i);
      if (i == 4) chk("C no overflow yet", overflow, 0);
      if (i == 5) chk("C overflow set", overflow, 1);
      if (sink_if.sink_valid && sink_if.sink_ready) begin
        if (n < 8)
          chk("C real", sink_if.sink_real, expc[n]);
        chk("C sop", sink_if.sink_sop, int'(n == 0));
        chk("C eop", sink_if.sink_eop, int'(n == 7));
        n++;
      end
      step();
    end
    sink_if.sink_ready = 1'b1;
    chk("C transfers", n, 8);
    chk("C overflow sticky", overflow, 1);
    chk("C frames_sent", frames_sent, 1);
    finish_frames(1, "C");

    // D: continuous, stop at wr_idx=3
    do_start(0);
    chk("D overflow cleared", overflow, 0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      sample_in = DW'(400 + i);
      stop = (i == 3);
      if (sink_if.sink_valid) begin
        chk("D real", sink_if.sink_real, 400 + n);
        chk("D sop", sink_if.sink_sop, int'(n == 0));
        chk("D eop", sink_if.sink_eop, int'(n == 7));
        n++;
      end
      step();
    end
    stop = 1'b0;
    chk("D transfers", n, 8);
    chk("D waiting busy", busy, 1);
    chk("D frames_sent", frames_sent, 1);
    finish_frames(1, "D");

    // E: reset mid-frame, then a fresh start
    do_start(0);
    for (int i = 0; i < 12; i++) begin
      sample_in = DW'(600 + i);
      step();
    end
    chk("E pre-reset frames_sent", frames_sent, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk_all_zero("E reset");
    do_start(1);
    sample_in = DW'(700);
    chk("E first valid", sink_if.sink_valid, 0);
    step();
    chk("E fresh valid", sink_if.sink_valid, 1);
    chk("E fresh real", sink_if.sink_real, 700);
    chk("E fresh sop", sink_if.sink_sop, 1);
    for (int i = 1; i < 12; i++) begin
      sample_in = DW'(700 + i);
      step();
    end
    chk("E frames_sent", frames_sent, 1);
    finish_frames(1, "E");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
